cpu_run_monitor: RTL and testbench

- Parametrised run monitor for the pipelined CPU bench.
- Detects the halt idiom at the writeback stage, waits a programmable drain interval, then asserts done.
- Captures every completed physical-memory line write for the autograder and flags a watchdog timeout.
- Sits between the toplevel pmem bus and the bench; it is purely an observer and never drives the bus.

---
 rtl/cpu_run_monitor.sv | 163 ++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// Run monitor: halt-idiom detection with drain delay, pmem line-write capture, watchdog.
// Optional CPU_RUN_MONITOR_PERF_EN adds the pmem stall counter.
module cpu_run_monitor #(
  parameter int unsigned LINE_WIDTH     = 256,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned OFFSET_BITS    = 5,
  parameter int unsigned DRAIN_CYCLES   = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wb_valid,
  input  logic [31:0]                        wb_instruction,
  input  logic [ADDR_WIDTH-1:0]              pmem_address,
  input  logic [LINE_WIDTH-1:0]              pmem_wdata,
  input  logic                               pmem_read,
  input  logic                               pmem_write,
  input  logic                               pmem_resp,
  output logic                               write,
  output logic [ADDR_WIDTH-OFFSET_BITS-1:0]  write_address,
  output logic [LINE_WIDTH-1:0]              write_data,
  output logic                               halt_seen,
  output logic                               done,
  output logic                               timeout,
  output logic [31:0]                        cycle_count,
  output logic [31:0]                        write_count,
  output logic [31:0]                        read_count,
  output logic [31:0]                        stall_count
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE, TOUT} state_e;

  state_e                            state_q, state_d;
  logic [7:0]                        drain_ctr_q, drain_ctr_d;
  logic                              halt_seen_q, halt_seen_d;
  logic                              done_q, done_d;
  logic                              timeout_q, timeout_d;
  logic                              write_q, write_d;
  logic [ADDR_WIDTH-OFFSET_BITS-1:0] write_address_q, write_address_d;
  logic [LINE_WIDTH-1:0]             write_data_q, write_data_d;
  logic [31:0]                       cycle_count_q, cycle_count_d;
  logic [31:0]                       write_count_q, write_count_d;
  logic [31:0]                       read_count_q, read_count_d;
  logic                              active;
  logic                              halt_cond;
  logic                              unused_offset_bits;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  assign active    = (state_q == RUN) || (state_q == DRAIN);
  assign halt_cond = wb_valid && (wb_instruction == 32'h0000_0063 ||
                                  wb_instruction == 32'h0000_006F);
  assign unused_offset_bits = ^pmem_address[OFFSET_BITS-1:0];

  always_comb begin
    state_d         = state_q;
    drain_ctr_d     = drain_ctr_q;
    halt_seen_d     = halt_seen_q;
    done_d          = done_q;
    timeout_d       = timeout_q;
    write_d         = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    cycle_count_d   = cycle_count_q;
    write_count_d   = write_count_q;
    read_count_d    = read_count_q;

    case (state_q)
      RUN: begin
        // Halt is tested first so it wins over a same-cycle watchdog expiry.
        if (halt_cond) begin
          state_d     = DRAIN;
          halt_seen_d = 1'b1;
          drain_ctr_d = 8'(DRAIN_CYCLES - 1);
        end else if (TIMEOUT_CYCLES != 0 &&
                     cycle_count_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d   = TOUT;
          timeout_d = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_ctr_q == 8'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          drain_ctr_d = drain_ctr_q - 8'd1;
        end
      end
      default: ;
    endcase

    if (active) begin
      cycle_count_d = sat_inc(cycle_count_q);
      if (pmem_write && pmem_resp) begin
        write_d         = 1'b1;
        write_address_d = pmem_address[ADDR_WIDTH-1:OFFSET_BITS];
        write_data_d    = pmem_wdata;
        write_count_d   = sat_inc(write_count_q);
      end
      if (pmem_read && pmem_resp) read_count_d = sat_inc(read_count_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= RUN;
      drain_ctr_q     <= '0;
      halt_seen_q     <= 1'b0;
      done_q          <= 1'b0;
      timeout_q       <= 1'b0;
      write_q         <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      cycle_count_q   <= '0;
      write_count_q   <= '0;
      read_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      drain_ctr_q     <= drain_ctr_d;
      halt_seen_q     <= halt_seen_d;
      done_q          <= done_d;
      timeout_q       <= timeout_d;
      write_q         <= write_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      cycle_count_q   <= cycle_count_d;
      write_count_q   <= write_count_d;
      read_count_q    <= read_count_d;
    end
  end

`ifdef CPU_RUN_MONITOR_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (active && (pmem_read || pmem_write) && !pmem_resp)
      stall_count_d = sat_inc(stall_count_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_count_q <= '0;
    else     stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = '0;
`endif

  assign write         = write_q;
  assign write_address = write_address_q;
  assign write_data    = write_data_q;
  assign halt_seen     = halt_seen_q;
  assign done          = done_q;
  assign timeout       = timeout_q;
  assign cycle_count   = cycle_count_q;
  assign write_count   = write_count_q;
  assign read_count    = read_count_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomized bench for cpu_run_monitor: two instances (watchdog 20 / disabled) share
// stimulus and are compared every cycle against an edge-number based reference model.
module tb_cpu_run_monitor;

  localparam int unsigned DRAIN = 5;
`ifdef CPU_RUN_MONITOR_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_valid;
  logic [31:0]  wb_instruction;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_read, pmem_write, pmem_resp;

  logic         write_o[2];
  logic [26:0]  write_address_o[2];
  logic [255:0] write_data_o[2];
  logic         halt_seen_o[2], done_o[2], timeout_o[2];
  logic [31:0]  cycle_count_o[2], write_count_o[2], read_count_o[2], stall_count_o[2];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  cpu_run_monitor #(.DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(20)) u_dut0 (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_instruction(wb_instruction),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .write(write_o[0]), .write_address(write_address_o[0]), .write_data(write_data_o[0]),
    .halt_seen(halt_seen_o[0]), .done(done_o[0]), .timeout(timeout_o[0]),
    .cycle_count(cycle_count_o[0]), .write_count(write_count_o[0]),
    .read_count(read_count_o[0]), .stall_count(stall_count_o[0]));

  cpu_run_monitor #(.DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_instruction(wb_instruction),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .write(write_o[1]), .write_address(write_address_o[1]), .write_data(write_data_o[1]),
    .halt_seen(halt_seen_o[1]), .done(done_o[1]), .timeout(timeout_o[1]),
    .cycle_count(cycle_count_o[1]), .write_count(write_count_o[1]),
    .read_count(read_count_o[1]), .stall_count(stall_count_o[1]));

  // Reference model: edges counted while monitoring; done is halt edge + DRAIN.
  int unsigned  p_tout[2] = '{20, 0};
  int unsigned  m_edge[2], m_halt_at[2];
  bit           m_halt[2], m_done[2], m_tout[2], m_wr[2];
  logic [26:0]  m_wa[2];
  logic [255:0] m_wd[2];
  logic [31:0]  m_cyc[2], m_wc[2], m_rc[2], m_sc[2];

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_edge[i] = 0; m_halt_at[i] = 0;
      m_halt[i] = 0; m_done[i] = 0; m_tout[i] = 0; m_wr[i] = 0;
      m_wa[i] = '0; m_wd[i] = '0;
      m_cyc[i] = '0; m_wc[i] = '0; m_rc[i] = '0; m_sc[i] = '0;
    end
  endtask

  task automatic model_step();
    bit          is_halt;
    logic [31:0] cyc_before;
    is_halt = wb_valid && (wb_instruction == 32'h63 || wb_instruction == 32'h6F);
    for (int i = 0; i < 2; i++) begin
      m_wr[i] = 0;
      if (!m_done[i] && !m_tout[i]) begin
        m_edge[i]++;
        cyc_before = m_cyc[i];
        m_cyc[i] = sat(m_cyc[i]);
        if (pmem_write && pmem_resp) begin
          m_wr[i] = 1;
          m_wa[i] = pmem_address[31:5];
          m_wd[i] = pmem_wdata;
          m_wc[i] = sat(m_wc[i]);
        end
        if (pmem_read && pmem_resp) m_rc[i] = sat(m_rc[i]);
        if (PERF && (pmem_read || pmem_write) && !pmem_resp) m_sc[i] = sat(m_sc[i]);
        if (m_halt[i]) begin
          if (m_edge[i] == m_halt_at[i] + DRAIN) m_done[i] = 1;
        end else if (is_halt) begin
          m_halt[i] = 1;
          m_halt_at[i] = m_edge[i];
        end else if (p_tout[i] != 0 && cyc_before == 32'(p_tout[i] - 1)) begin
          m_tout[i] = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d.write", i),         256'(write_o[i]),         256'(m_wr[i]));
      check_eq($sformatf("u%0d.write_address", i), 256'(write_address_o[i]), 256'(m_wa[i]));
      check_eq($sformatf("u%0d.write_data", i),    write_data_o[i],          m_wd[i]);
      check_eq($sformatf("u%0d.halt_seen", i),     256'(halt_seen_o[i]),     256'(m_halt[i]));
      check_eq($sformatf("u%0d.done", i),          256'(done_o[i]),          256'(m_done[i]));
      check_eq($sformatf("u%0d.timeout", i),       256'(timeout_o[i]),       256'(m_tout[i]));
      check_eq($sformatf("u%0d.cycle_count", i),   256'(cycle_count_o[i]),   256'(m_cyc[i]));
      check_eq($sformatf("u%0d.write_count", i),   256'(write_count_o[i]),   256'(m_wc[i]));
      check_eq($sformatf("u%0d.read_count", i),    256'(read_count_o[i]),    256'(m_rc[i]));
      check_eq($sformatf("u%0d.stall_count", i),   256'(stall_count_o[i]),   256'(m_sc[i]));
    end
  endtask

  task automatic rand_wdata();
    for (int k = 0; k < 8; k++) pmem_wdata[k*32 +: 32] = $urandom;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_instruction = 32'h13;
    pmem_read = 0; pmem_write = 0; pmem_resp = 0; pmem_address = '0;
  endtask

  task automatic drive_random(input bit allow_halt);
    wb_valid = 1'($urandom % 2);
    case ($urandom % 4)
      0: wb_instruction = 32'h63;
      1: wb_instruction = 32'h6F;
      2: wb_instruction = 32'h67;
      default: wb_instruction = $urandom;
    endcase
    if ((wb_instruction == 32'h63 || wb_instruction == 32'h6F) &&
        !(allow_halt && ($urandom % 8 == 0))) wb_valid = 0;
    pmem_read    = ($urandom % 3 == 0);
    pmem_write   = ($urandom % 3 == 0);
    pmem_resp    = 1'($urandom % 2);
    pmem_address = $urandom;
    rand_wdata();
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic apply_reset(input int unsigned n);
    rst = 1;
    model_reset();
    #1;
    check_outputs();
    repeat (n) begin
      @(posedge clk);
      #1;
      check_outputs();
    end
    rst = 0;
  endtask

  logic [255:0] line_a, line_b;

  initial begin
    rst = 1;
    idle_inputs();
    pmem_wdata = '0;
    @(negedge clk);
    apply_reset(3);

    // Directed: read stall, non-halt words, two back-to-back writes, halt at edge 10.
    for (int e = 1; e <= 20; e++) begin
      idle_inputs();
      if (e <= 4) begin pmem_read = 1; pmem_resp = (e == 4); end
      if (e == 2) begin wb_valid = 0; wb_instruction = 32'h63; end
      if (e == 3) begin wb_valid = 1; wb_instruction = 32'h67; end
      if (e == 6 || e == 7 || e == 17) begin
        pmem_write = 1; pmem_resp = 1;
        pmem_address = (e == 6) ? 32'h60 : (e == 7) ? 32'h80 : 32'hA0;
        rand_wdata();
        if (e == 6) line_a = pmem_wdata;
        if (e == 7) line_b = pmem_wdata;
      end
      if (e == 10 || e == 12) begin wb_valid = 1; wb_instruction = (e == 10) ? 32'h6F : 32'h63; end
      step();
      if (e == 3)  check_eq("nonhalt.halt_seen", 256'(halt_seen_o[0]), 256'(0));
      if (e == 4) begin
        check_eq("perf.read_count",  256'(read_count_o[0]),  256'(1));
        check_eq("perf.stall_count", 256'(stall_count_o[0]), PERF ? 256'(3) : 256'(0));
      end
      if (e == 6) begin
        check_eq("wr0.address", 256'(write_address_o[0]), 256'(27'h3));
        check_eq("wr0.data",    write_data_o[0],           line_a);
      end
      if (e == 7) begin
        check_eq("wr1.pulse",   256'(write_o[0]),          256'(1));
        check_eq("wr1.address", 256'(write_address_o[0]), 256'(27'h4));
        check_eq("wr1.data",    write_data_o[0],           line_b);
        check_eq("wr1.count",   256'(write_count_o[0]),    256'(2));
      end
      if (e == 10) check_eq("halt.halt_seen", 256'(halt_seen_o[0]), 256'(1));
      if (e == 14) check_eq("drain.done_early", 256'(done_o[0]), 256'(0));
      if (e == 15) check_eq("drain.done", 256'(done_o[0]), 256'(1));
      if (e == 17) check_eq("afterdone.write", 256'(write_o[0]), 256'(0));
    end
    check_eq("halt.cycle_frozen", 256'(cycle_count_o[0]), 256'(15));

    // Reset asserted for 3 cycles in the middle of the drain interval.
    apply_reset(1);
    for (int e = 1; e <= 5; e++) begin
      idle_inputs();
      if (e == 3) begin wb_valid = 1; wb_instruction = 32'h63; end
      step();
    end
    apply_reset(3);
    idle_inputs();
    step();
    check_eq("rst.cycle_restart", 256'(cycle_count_o[0]), 256'(1));
    check_eq("rst.halt_clear",    256'(halt_seen_o[0]),   256'(0));

    // Watchdog: no halt; instance 0 expires, instance 1 runs 10000 cycles.
    apply_reset(2);
    for (int e = 1; e <= 10000; e++) begin
      drive_random(1'b0);
      step();
      if (e == 19) check_eq("wdog.early", 256'(timeout_o[0]), 256'(0));
      if (e == 20) begin
        check_eq("wdog.timeout", 256'(timeout_o[0]),     256'(1));
        check_eq("wdog.cycles",  256'(cycle_count_o[0]), 256'(20));
      end
      if (e == 25) check_eq("wdog.frozen", 256'(cycle_count_o[0]), 256'(20));
    end
    check_eq("nowdog.timeout", 256'(timeout_o[1]),     256'(0));
    check_eq("nowdog.cycles",  256'(cycle_count_o[1]), 256'(10000));

    // Halt on the same edge the watchdog would expire: halt wins.
    apply_reset(2);
    for (int e = 1; e <= 30; e++) begin
      idle_inputs();
      if (e == 20) begin wb_valid = 1; wb_instruction = 32'h63; end
      step();
      if (e == 20) begin
        check_eq("race.halt_seen", 256'(halt_seen_o[0]), 256'(1));
        check_eq("race.timeout",   256'(timeout_o[0]),   256'(0));
      end
      if (e == 25) check_eq("race.done", 256'(done_o[0]), 256'(1));
    end

    // Random runs with occasional halts.
    for (int it = 0; it < 20; it++) begin
      apply_reset(1 + $urandom % 3);
      for (int c = 0; c < 60; c++) begin
        drive_random(1'b1);
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
